// File: rtl/rotate_right_pipe_pkg.sv
// Shared helpers for the rotate barrel-shifter family: amount/stage sizing
// and the legal word-width check.
package rotate_right_pipe_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << result) < value) result = result + 1;
    end
    return result;
  endfunction

  // Words must be a power of two so every amount maps onto whole stages.
  function automatic bit width_is_legal(input int width);
    return (width >= 2) && ((width & (width - 1)) == 0);
  endfunction

endpackage

// File: rtl/rotate_right_shifter.sv
// One fixed-distance rotate-right stage: rotates by N when shift is set,
// otherwise passes the word through.
module rotate_right_shifter #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 1
) (
  input  logic [DATA_WIDTH-1:0] idata,
  input  logic                  shift,
  output logic [DATA_WIDTH-1:0] odata
);

  assign odata = shift ? {idata[N-1:0], idata[DATA_WIDTH-1:N]} : idata;

endmodule

// File: rtl/rotate_right_pipe.sv
// Pipelined rotate-right barrel shifter: one registered stage per amount bit,
// valid/ready at both ends, whole-pipe stall on backpressure.
module rotate_right_pipe
  import rotate_right_pipe_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int AMT_WIDTH  = clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ivalid,
  output logic                  iready,
  input  logic [DATA_WIDTH-1:0] idata,
  input  logic [AMT_WIDTH-1:0]  iamt,
  output logic                  ovalid,
  input  logic                  oready,
  output logic [DATA_WIDTH-1:0] odata
);

  if (!width_is_legal(DATA_WIDTH)) begin : g_bad_width
    $error("rotate_right_pipe: DATA_WIDTH must be a power of two >= 2");
  end

  logic                  adv;
  logic [AMT_WIDTH-1:0]  stage_valid;
  logic [DATA_WIDTH-1:0] stage_data [AMT_WIDTH];
  logic [AMT_WIDTH-1:0]  stage_amt  [AMT_WIDTH];

  logic [AMT_WIDTH-1:0]  src_valid;
  logic [DATA_WIDTH-1:0] src_data   [AMT_WIDTH];
  logic [AMT_WIDTH-1:0]  src_amt    [AMT_WIDTH];
  logic [DATA_WIDTH-1:0] shifted    [AMT_WIDTH];

  // The pipe moves as one unit: any free output slot lets every stage advance.
  assign adv    = ~ovalid | oready;
  assign iready = adv;
  assign ovalid = stage_valid[AMT_WIDTH-1];
  assign odata  = stage_data[AMT_WIDTH-1];

  always_comb begin
    src_valid[0] = ivalid;
    src_data[0]  = idata;
    src_amt[0]   = iamt;
    for (int k = 1; k < AMT_WIDTH; k++) begin
      src_valid[k] = stage_valid[k-1];
      src_data[k]  = stage_data[k-1];
      src_amt[k]   = stage_amt[k-1];
    end
  end

  for (genvar k = 0; k < AMT_WIDTH; k++) begin : g_stage
    rotate_right_shifter #(
      .DATA_WIDTH (DATA_WIDTH),
      .N          (1 << k)
    ) u_shift (
      .idata (src_data[k]),
      .shift (src_amt[k][k]),
      .odata (shifted[k])
    );
  end

  // NOTE: the stage registers are a handful of flops, not a RAM, so they are
  // all cleared on reset; <= keeps every stage sampling its predecessor's old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid <= '0;
      for (int k = 0; k < AMT_WIDTH; k++) begin
        stage_data[k] <= '0;
        stage_amt[k]  <= '0;
      end
    end else if (adv) begin
      stage_valid <= src_valid;
      for (int k = 0; k < AMT_WIDTH; k++) begin
        stage_data[k] <= shifted[k];
        stage_amt[k]  <= src_amt[k];
      end
    end
  end

endmodule

// File: tb/tb_rotate_right_pipe.sv
// Self-checking bench for rotate_right_pipe: scoreboard on the 32-bit
// instance plus directed timing checks and a small 8-bit instance.
module tb_rotate_right_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        ivalid;
  logic        iready;
  logic [31:0] idata;
  logic [4:0]  iamt;
  logic        ovalid;
  logic        oready;
  logic [31:0] odata;

  logic        ivalid8;
  logic        iready8;
  logic [7:0]  idata8;
  logic [2:0]  iamt8;
  logic        ovalid8;
  logic        oready8;
  logic [7:0]  odata8;

  int          errors   = 0;
  int          checks   = 0;
  int          n_popped = 0;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  rotate_right_pipe #(.DATA_WIDTH(32)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .ivalid (ivalid),
    .iready (iready),
    .idata  (idata),
    .iamt   (iamt),
    .ovalid (ovalid),
    .oready (oready),
    .odata  (odata)
  );

  rotate_right_pipe #(.DATA_WIDTH(8)) u_dut8 (
    .clk    (clk),
    .rst    (rst),
    .ivalid (ivalid8),
    .iready (iready8),
    .idata  (idata8),
    .iamt   (iamt8),
    .ovalid (ovalid8),
    .oready (oready8),
    .odata  (odata8)
  );

  function automatic logic [31:0] ref_ror32(input logic [31:0] d, input logic [4:0] a);
    logic [31:0] r;
    r = (d >> a) | (d << (6'd32 - {1'b0, a}));
    return r;
  endfunction

  // Handshakes are sampled mid-cycle; they commit at the following rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (ivalid && iready) sb.push_back(ref_ror32(idata, iamt));
      if (ovalid && oready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got odata=%h, want no output (queue empty)", odata);
        end else begin
          logic [31:0] exp;
          exp = sb.pop_front();
          n_popped++;
          if (odata !== exp) begin
            errors++;
            $display("FAIL sb_data: got odata=%h, want %h", odata, exp);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || ovalid) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0 || ovalid) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending, want 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ivalid = 1'b0; idata = '0; iamt = '0; oready = 1'b1;
    ivalid8 = 1'b0; idata8 = '0; iamt8 = '0; oready8 = 1'b1;
    tick(); tick();
    checks++; if (ovalid !== 1'b0)   begin errors++; $display("FAIL reset_ovalid: got %b want 0", ovalid); end
    checks++; if (odata !== 32'h0)   begin errors++; $display("FAIL reset_odata: got %h want 0", odata); end
    checks++; if (iready !== 1'b1)   begin errors++; $display("FAIL reset_iready: got %b want 1", iready); end
    checks++; if (ovalid8 !== 1'b0)  begin errors++; $display("FAIL reset_ovalid8: got %b want 0", ovalid8); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    oready = 1'b1;
    ivalid = 1'b1; idata = 32'h8000_0001; iamt = 5'd1;
    tick();
    ivalid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      checks++;
      if (iready !== 1'b1) begin errors++; $display("FAIL single_iready c%0d: got %b want 1", i, iready); end
      checks++;
      if (ovalid !== (i == 5)) begin errors++; $display("FAIL single_ovalid c%0d: got %b want %b", i, ovalid, i == 5); end
      if (i == 5) begin
        checks++;
        if (odata !== 32'hC000_0000) begin errors++; $display("FAIL single_odata: got %h want c0000000", odata); end
      end
      if (i < 6) tick();
    end
    wait_drain("single");
  endtask

  task automatic test_back_to_back();
    logic [4:0]  amts [4];
    logic [31:0] exps [4];
    amts = '{5'd0, 5'd4, 5'd16, 5'd31};
    exps = '{32'h1234_5678, 32'h8123_4567, 32'h5678_1234, 32'h2468_ACF0};
    oready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ivalid = 1'b1; idata = 32'h1234_5678; iamt = amts[i];
      tick();
    end
    ivalid = 1'b0;
    // Now one cycle after the 4th input edge; first result appears at cycle 5.
    for (int c = 4; c <= 9; c++) begin
      checks++;
      if (ovalid !== (c >= 5 && c <= 8)) begin
        errors++; $display("FAIL b2b_ovalid c%0d: got %b want %b", c, ovalid, (c >= 5 && c <= 8));
      end
      if (c >= 5 && c <= 8) begin
        checks++;
        if (odata !== exps[c-5]) begin errors++; $display("FAIL b2b_odata c%0d: got %h want %h", c, odata, exps[c-5]); end
      end
      tick();
    end
    wait_drain("b2b");
  endtask

  task automatic test_backpressure();
    logic [31:0] first;
    int          start;
    int          n;
    oready = 1'b0;
    start  = n_popped;
    for (int i = 0; i < 5; i++) begin
      ivalid = 1'b1; idata = $urandom; iamt = 5'($urandom_range(0, 31));
      tick();
    end
    ivalid = 1'b0;
    checks++; if (ovalid !== 1'b1) begin errors++; $display("FAIL bp_full_ovalid: got %b want 1", ovalid); end
    checks++; if (iready !== 1'b0) begin errors++; $display("FAIL bp_full_iready: got %b want 0", iready); end
    checks++; if (sb.size() != 5)  begin errors++; $display("FAIL bp_accepted: got %0d want 5", sb.size()); end
    first = sb[0];
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (odata !== first || ovalid !== 1'b1) begin
        errors++; $display("FAIL bp_hold c%0d: got %b/%h want 1/%h", i, ovalid, odata, first);
      end
      tick();
    end
    oready = 1'b1;
    n = 0;
    while (n_popped - start < 5 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n_popped - start != 5) begin errors++; $display("FAIL bp_count: got %0d want 5", n_popped - start); end
    wait_drain("bp");
  endtask

  task automatic test_random();
    int  sent;
    int  cyc;
    bit  fired;
    sent = 0;
    cyc  = 0;
    ivalid = 1'b0;
    while (sent < 1000 && cyc < 20000) begin
      if (!ivalid) begin
        idata  = $urandom;
        iamt   = 5'($urandom_range(0, 31));
        ivalid = ($urandom_range(0, 3) != 0);
      end
      oready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      fired = ivalid && iready;
      tick();
      cyc++;
      if (fired) begin
        sent++;
        ivalid = 1'b0;
      end
    end
    ivalid = 1'b0;
    oready = 1'b1;
    checks++;
    if (sent != 1000) begin errors++; $display("FAIL rand_sent: got %0d want 1000", sent); end
    wait_drain("rand");
  endtask

  task automatic test_reset_midflight();
    int n;
    oready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ivalid = 1'b1; idata = $urandom | 32'h1; iamt = 5'($urandom_range(0, 31));
      tick();
    end
    ivalid = 1'b0;
    n = 0;
    while (!ovalid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (ovalid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_ovalid: got %b want 1", ovalid); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (ovalid !== 1'b0)  begin errors++; $display("FAIL rstmid_ovalid: got %b want 0", ovalid); end
    checks++; if (odata !== 32'h0)  begin errors++; $display("FAIL rstmid_odata: got %h want 0", odata); end
    sb.delete();
    tick();
    rst = 1'b0;
    tick();
    oready = 1'b1;
    ivalid = 1'b1; idata = 32'h0000_000F; iamt = 5'd4;
    tick();
    ivalid = 1'b0;
    for (int i = 1; i < 5; i++) tick();
    checks++; if (ovalid !== 1'b1)         begin errors++; $display("FAIL rstmid_new_ovalid: got %b want 1", ovalid); end
    checks++; if (odata !== 32'hF000_0000) begin errors++; $display("FAIL rstmid_new_odata: got %h want f0000000", odata); end
    wait_drain("rstmid");
  endtask

  task automatic test_width8();
    logic [7:0] d8 [2];
    logic [2:0] a8 [2];
    logic [7:0] e8 [2];
    d8 = '{8'hA5, 8'h81};
    a8 = '{3'd3, 3'd7};
    e8 = '{8'hB4, 8'h03};
    oready8 = 1'b1;
    for (int t = 0; t < 2; t++) begin
      ivalid8 = 1'b1; idata8 = d8[t]; iamt8 = a8[t];
      tick();
      ivalid8 = 1'b0;
      for (int i = 1; i <= 3; i++) begin
        checks++;
        if (ovalid8 !== (i == 3)) begin errors++; $display("FAIL w8_ovalid t%0d c%0d: got %b want %b", t, i, ovalid8, i == 3); end
        if (i == 3) begin
          checks++;
          if (odata8 !== e8[t]) begin errors++; $display("FAIL w8_odata t%0d: got %h want %h", t, odata8, e8[t]); end
        end else begin
          tick();
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    test_width8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rotate_right_pipe.md
Name: rotate_right_pipe

Overview:
Pipelined rotate-right barrel shifter with valid/ready handshake at both ends. It is the right-rotating counterpart of the existing left-rotate barrel-shifter stages and serves ALU/crypto datapaths that need ROR at full clock rate. It uses log2(DATA_WIDTH) registered stages; stage k rotates right by 2^k when bit k of the amount is set. Throughput is one operation per cycle, and backpressure stalls the whole pipe.

Parameters:
- DATA_WIDTH, 32, word width; must be a power of two, >= 2.
- AMT_WIDTH, $clog2(DATA_WIDTH) (localparam, not overridable), amount width and number of pipeline stages.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- IVALID  input  1  input word/amount valid.
- IREADY  output  1  block can accept input this cycle.
- IDATA  input  DATA_WIDTH  word to rotate.
- IAMT  input  AMT_WIDTH  rotate-right amount, 0..DATA_WIDTH-1.
- OVALID  output  1  ODATA holds a valid result.
- OREADY  input  1  downstream accepts ODATA this cycle.
- ODATA  output  DATA_WIDTH  rotated result = IDATA ROR IAMT.

Behaviour:
- Reset (async assert, sync release): all stage valid bits = 0, so OVALID = 0; all stage data/amount registers = 0, so ODATA = 0.
- Global advance: ADV = ~OVALID | OREADY. IREADY = ADV (combinational from OVALID/OREADY only; no dependence on IVALID).
- Input transfer: IVALID & IREADY on a rising edge. Output transfer: OVALID & OREADY.
- Stage k, for k = 0..AMT_WIDTH-1, holds {valid_k, data_k, amt_k}.
  - Stage 0 loads from IDATA/IAMT.
  - Stage k loads from stage k-1.
  - Loaded data = previous data rotated right by 2^k if the amount bit k is set, else unchanged.
  - The full amount is carried along; only bit k is consumed at stage k.
- When ADV = 1, every stage loads from its predecessor. valid_0 <= IVALID. When ADV = 0, every stage holds its value.
- ODATA/OVALID come from the last stage (register outputs, no combinational path from IDATA).
- Latency: AMT_WIDTH cycles from input transfer to OVALID (5 for DATA_WIDTH = 32), with no stall.
- Ordering: results are strictly in input order. There is no drop or duplication; a stalled OVALID result keeps ODATA stable until accepted.
- Bubbles: invalid slots propagate like data. Data registers of invalid slots may update (don't-care), but OVALID = 0 for them.
- Amount 0: pass-through. Amounts are always modulo DATA_WIDTH by construction (AMT_WIDTH bits), so no out-of-range case exists.
- Simultaneous input and output transfer in the same cycle, with a full pipe: allowed, throughput of 1/cycle.
- Reset mid-operation: all in-flight items are discarded immediately (async). OVALID falls to 0 without waiting for a clock edge.
- IVALID while IREADY = 0: ignored (producer must hold it); no state change.

Decomposition:
- Shared barrel-shifter package: function clog2 (if the tool lacks $clog2), and a check on the legal DATA_WIDTH range.
- Sub-module rotate_right_shifter #(DATA_WIDTH, N), mirroring the left-rotate stage interface (IDATA, SHIFT, ODATA):
  - ODATA = SHIFT ? {IDATA[N-1:0], IDATA[DATA_WIDTH-1:N]} : IDATA.
  - It is instantiated once per stage with N = 2^k, inside a generate loop.
  - Pipeline registers and handshake logic live in rotate_right_pipe.

Test Plan:
- Reset, then IDATA = 0x80000001, IAMT = 1, single beat with OREADY = 1 -> OVALID rises exactly 5 cycles later with ODATA = 0xC0000000 for one cycle; IREADY stays 1 throughout.
- Back-to-back 0x12345678 with IAMT = 0, 4, 16, 31 on consecutive cycles -> ODATA = 0x12345678, 0x81234567, 0x56781234, 0x2468ACF0 on consecutive cycles, starting at cycle 5.
- Fill the pipe with 5 items while OREADY = 0 -> IREADY = 0 once OVALID = 1; ODATA is held stable. Then release OREADY -> all 5 results appear in order, with no loss or duplicates.
- Random IVALID/OREADY toggling, 1000 random words/amounts -> scoreboard matches (IDATA >> IAMT) | (IDATA << (32 - IAMT)) for every transfer, in order.
- Assert RST with 3 items in flight -> OVALID = 0 and ODATA = 0 immediately (before the next edge). After release, a new item 0x0000000F with IAMT = 4 -> ODATA = 0xF0000000 after 5 cycles.
- DATA_WIDTH = 8 instance: 0xA5 with IAMT = 3 -> 0xB4 after 3 cycles.
